fetch_unit: RTL and testbench

Instruction-fetch stage that consumes the branch-resolution outputs from EX (`Flush` plus the resolved branch target) and the stall from the hazard unit. It generates the program counter, drives a synchronous-read instruction memory, and loads the IF/ID pipeline register. On a flush it discards wrong-path fetches and inserts bubbles. It also traps misaligned branch targets and counts taken redirects.

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_unit_if.sv | 20 ++
 rtl/fetch_unit_sat_counter.sv | 29 ++
 rtl/fetch_unit.sv | 178 +++++++++++++++++
 tb/tb_fetch_unit.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants, state encoding and helpers for the instruction-fetch stage.
package fetch_pkg;

  // Canonical RISC-V NOP (addi x0, x0, 0) used to fill IF/ID bubbles.
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // Low address bits that must be zero for a 4-byte aligned target.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  // Fetch sequencing states.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  // True when the low address bits of a target violate word alignment.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return ((addr_lsb & ALIGN_MASK) != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage (master) and a synchronous-read memory (slave).
interface fetch_unit_if #(
  parameter int XLEN = 64
);
  logic [XLEN-1:0] imem_addr;
  logic            imem_en;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_addr,
    output imem_en,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    input  imem_en,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_VAL = {W{1'b1}};
  localparam logic [W-1:0] ONE_VAL = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_count;

  // Count accepted events, sticking at the all-ones value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= {W{1'b0}};
    end else if (inc && (r_count != MAX_VAL)) begin
      r_count <= r_count + ONE_VAL;
    end else begin
      r_count <= r_count;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generation, synchronous-read imem control, IF/ID register,
// flush bubbling, misaligned-target trapping and a saturating redirect counter.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0,
  parameter logic [XLEN-1:0] TRAP_VEC = 64'h100,
  parameter int              CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_flush,
  input  logic [XLEN-1:0]   i_branch_target,
  input  logic              i_stall,
  fetch_unit_if.master      imem,
  output logic [XLEN-1:0]   o_ifid_pc,
  output logic [31:0]       o_ifid_instr,
  output logic              o_ifid_valid,
  output logic              o_misalign_err,
  output logic [XLEN-1:0]   o_misalign_addr,
  output logic [CNT_W-1:0]  o_flush_count
);

  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [XLEN-1:0] ZERO_X  = {XLEN{1'b0}};

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_pc;
  logic            r_req_valid;
  logic [XLEN-1:0] r_ifid_pc;
  logic [31:0]     r_ifid_instr;
  logic            r_ifid_valid;
  logic            r_misalign_err;
  logic [XLEN-1:0] r_misalign_addr;

  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_req_pc_nxt;
  logic            w_req_valid_nxt;
  logic [XLEN-1:0] w_ifid_pc_nxt;
  logic [31:0]     w_ifid_instr_nxt;
  logic            w_ifid_valid_nxt;
  logic            w_misalign_err_nxt;
  logic [XLEN-1:0] w_misalign_addr_nxt;
  logic            w_misaligned;
  logic [XLEN-1:0] w_tgt;
  logic [CNT_W-1:0] w_flush_count;

  // A misaligned redirect is steered to the trap vector instead of the bad address.
  always_comb begin
    w_misaligned = is_misaligned(i_branch_target[1:0]);
    if (w_misaligned) begin
      w_tgt = TRAP_VEC;
    end else begin
      w_tgt = i_branch_target;
    end
  end

  // Memory request: a flush presents its target immediately; BOOT always fetches.
  always_comb begin
    imem.imem_addr = r_pc;
    imem.imem_en   = 1'b0;
    if (i_flush) begin
      imem.imem_addr = w_tgt;
      imem.imem_en   = 1'b1;
    end else if (r_state == BOOT) begin
      imem.imem_addr = r_pc;
      imem.imem_en   = 1'b1;
    end else begin
      imem.imem_addr = r_pc;
      imem.imem_en   = ~i_stall;
    end
  end

  // Next-state and next-register computation; flush beats stall beats normal flow.
  always_comb begin
    w_state_nxt         = r_state;
    w_pc_nxt            = r_pc;
    w_req_pc_nxt        = r_req_pc;
    w_req_valid_nxt     = r_req_valid;
    w_ifid_pc_nxt       = r_ifid_pc;
    w_ifid_instr_nxt    = r_ifid_instr;
    w_ifid_valid_nxt    = r_ifid_valid;
    w_misalign_err_nxt  = r_misalign_err;
    w_misalign_addr_nxt = r_misalign_addr;

    if (i_flush) begin
      // Wrong-path data in flight is dropped; target fetch is issued this cycle.
      w_pc_nxt         = w_tgt + PC_STEP;
      w_req_pc_nxt     = w_tgt;
      w_req_valid_nxt  = 1'b1;
      w_ifid_pc_nxt    = ZERO_X;
      w_ifid_instr_nxt = NOP_INSTR;
      w_ifid_valid_nxt = 1'b0;
      w_state_nxt      = RUN;
      if (w_misaligned && !r_misalign_err) begin
        w_misalign_err_nxt  = 1'b1;
        w_misalign_addr_nxt = i_branch_target;
      end else begin
        w_misalign_err_nxt  = r_misalign_err;
        w_misalign_addr_nxt = r_misalign_addr;
      end
    end else begin
      case (r_state)
        BOOT: begin
          // First fetch after reset; nothing is in flight yet, so IF/ID stays a bubble.
          w_req_pc_nxt     = r_pc;
          w_req_valid_nxt  = 1'b1;
          w_pc_nxt         = r_pc + PC_STEP;
          w_ifid_pc_nxt    = ZERO_X;
          w_ifid_instr_nxt = NOP_INSTR;
          w_ifid_valid_nxt = 1'b0;
          w_state_nxt      = RUN;
        end
        RUN, HOLD: begin
          if (!i_stall) begin
            w_ifid_pc_nxt    = r_req_pc;
            w_ifid_instr_nxt = imem.imem_rdata;
            w_ifid_valid_nxt = r_req_valid;
            w_req_pc_nxt     = r_pc;
            w_pc_nxt         = r_pc + PC_STEP;
            w_state_nxt      = RUN;
          end else begin
            // Memory is disabled, so its held output stays paired with req_pc.
            w_state_nxt = HOLD;
          end
        end
        default: begin
          w_state_nxt = BOOT;
        end
      endcase
    end
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= BOOT;
      r_pc            <= RESET_PC;
      r_req_pc        <= ZERO_X;
      r_req_valid     <= 1'b0;
      r_ifid_pc       <= ZERO_X;
      r_ifid_instr    <= NOP_INSTR;
      r_ifid_valid    <= 1'b0;
      r_misalign_err  <= 1'b0;
      r_misalign_addr <= ZERO_X;
    end else begin
      r_state         <= w_state_nxt;
      r_pc            <= w_pc_nxt;
      r_req_pc        <= w_req_pc_nxt;
      r_req_valid     <= w_req_valid_nxt;
      r_ifid_pc       <= w_ifid_pc_nxt;
      r_ifid_instr    <= w_ifid_instr_nxt;
      r_ifid_valid    <= w_ifid_valid_nxt;
      r_misalign_err  <= w_misalign_err_nxt;
      r_misalign_addr <= w_misalign_addr_nxt;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (i_flush),
    .count (w_flush_count)
  );

  assign o_ifid_pc       = r_ifid_pc;
  assign o_ifid_instr    = r_ifid_instr;
  assign o_ifid_valid    = r_ifid_valid;
  assign o_misalign_err  = r_misalign_err;
  assign o_misalign_addr = r_misalign_addr;
  assign o_flush_count   = w_flush_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit with a word[i]=i synchronous-read memory.
module tb_fetch_unit;

  localparam int XLEN  = 64;
  localparam int CNT_W = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic             clk;
  logic             reset;
  logic             i_flush;
  logic [XLEN-1:0]  i_branch_target;
  logic             i_stall;
  logic [XLEN-1:0]  o_ifid_pc;
  logic [31:0]      o_ifid_instr;
  logic             o_ifid_valid;
  logic             o_misalign_err;
  logic [XLEN-1:0]  o_misalign_addr;
  logic [CNT_W-1:0] o_flush_count;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  typedef struct {
    logic            valid;
    logic [XLEN-1:0] pc;
  } exp_t;

  exp_t sb_q[$];

  fetch_unit_if #(.XLEN(XLEN)) bus ();

  fetch_unit #(
    .XLEN     (XLEN),
    .RESET_PC (64'h0),
    .TRAP_VEC (64'h100),
    .CNT_W    (CNT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_flush         (i_flush),
    .i_branch_target (i_branch_target),
    .i_stall         (i_stall),
    .imem            (bus.master),
    .o_ifid_pc       (o_ifid_pc),
    .o_ifid_instr    (o_ifid_instr),
    .o_ifid_valid    (o_ifid_valid),
    .o_misalign_err  (o_misalign_err),
    .o_misalign_addr (o_misalign_addr),
    .o_flush_count   (o_flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory: word at byte address a holds a/4; holds output when disabled.
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= bus.imem_addr[33:2];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, check memory request, push expected IF/ID, clock, pop and compare.
  task automatic cyc(input logic fl, input logic [63:0] tgt, input logic st,
                     input logic [63:0] exp_addr, input logic exp_en,
                     input logic exp_v, input logic [63:0] exp_pc);
    exp_t e;
    exp_t got;
    i_flush = fl;
    i_branch_target = tgt;
    i_stall = st;
    #2;
    chk("imem_addr", bus.imem_addr, exp_addr);
    chk("imem_en", {63'd0, bus.imem_en}, {63'd0, exp_en});
    e.valid = exp_v;
    e.pc = exp_v ? exp_pc : 64'd0;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    chk("ifid_valid", {63'd0, o_ifid_valid}, {63'd0, got.valid});
    chk("ifid_pc", o_ifid_pc, got.pc);
    chk("ifid_instr", {32'd0, o_ifid_instr},
        got.valid ? {32'd0, got.pc[33:2]} : {32'd0, NOP});
  endtask

  task automatic chk_reset_state();
    chk("rst_ifid_valid", {63'd0, o_ifid_valid}, 64'd0);
    chk("rst_ifid_instr", {32'd0, o_ifid_instr}, {32'd0, NOP});
    chk("rst_ifid_pc", o_ifid_pc, 64'd0);
    chk("rst_misalign_err", {63'd0, o_misalign_err}, 64'd0);
    chk("rst_misalign_addr", o_misalign_addr, 64'd0);
    chk("rst_flush_count", {60'd0, o_flush_count}, 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    i_flush = 1'b0;
    i_branch_target = 64'd0;
    i_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state();
    reset = 1'b0;

    // Boot and steady fetch: 0,4,8,12 issued; IF/ID valid from the 2nd edge.
    cyc(1'b0, 64'd0, 1'b0, 64'h0,  1'b1, 1'b0, 64'h0);
    cyc(1'b0, 64'd0, 1'b0, 64'h4,  1'b1, 1'b1, 64'h0);
    cyc(1'b0, 64'd0, 1'b0, 64'h8,  1'b1, 1'b1, 64'h4);
    cyc(1'b0, 64'd0, 1'b0, 64'hC,  1'b1, 1'b1, 64'h8);

    // Three stall cycles: memory disabled, IF/ID holds (8,2), PC holds at 16.
    for (int i = 0; i < 3; i++) cyc(1'b0, 64'd0, 1'b1, 64'h10, 1'b0, 1'b1, 64'h8);
    cyc(1'b0, 64'd0, 1'b0, 64'h10, 1'b1, 1'b1, 64'hC);
    cyc(1'b0, 64'd0, 1'b0, 64'h14, 1'b1, 1'b1, 64'h10);

    // Flush to 0x40: one bubble, then the target instruction.
    cyc(1'b1, 64'h40, 1'b0, 64'h40, 1'b1, 1'b0, 64'h0);
    cyc(1'b0, 64'd0,  1'b0, 64'h44, 1'b1, 1'b1, 64'h40);
    chk("flush_count_1", {60'd0, o_flush_count}, 64'd1);
    cyc(1'b0, 64'd0,  1'b0, 64'h48, 1'b1, 1'b1, 64'h44);

    // Flush together with stall: flush wins, held instruction dropped.
    cyc(1'b1, 64'h80, 1'b1, 64'h80, 1'b1, 1'b0, 64'h0);
    cyc(1'b0, 64'd0,  1'b0, 64'h84, 1'b1, 1'b1, 64'h80);
    chk("flush_count_2", {60'd0, o_flush_count}, 64'd2);

    // Misaligned target traps to 0x100 and records the first offender.
    cyc(1'b1, 64'h42, 1'b0, 64'h100, 1'b1, 1'b0, 64'h0);
    chk("misalign_err", {63'd0, o_misalign_err}, 64'd1);
    chk("misalign_addr", o_misalign_addr, 64'h42);
    cyc(1'b0, 64'd0,  1'b0, 64'h104, 1'b1, 1'b1, 64'h100);
    cyc(1'b1, 64'h46, 1'b0, 64'h100, 1'b1, 1'b0, 64'h0);
    chk("misalign_addr_sticky", o_misalign_addr, 64'h42);
    chk("misalign_err_sticky", {63'd0, o_misalign_err}, 64'd1);
    cyc(1'b0, 64'd0,  1'b0, 64'h104, 1'b1, 1'b1, 64'h100);
    chk("flush_count_4", {60'd0, o_flush_count}, 64'd4);

    // 20 back-to-back flushes: last target wins, counter saturates at 15.
    for (int i = 0; i < 20; i++) cyc(1'b1, 64'h200, 1'b0, 64'h200, 1'b1, 1'b0, 64'h0);
    chk("flush_count_sat", {60'd0, o_flush_count}, 64'd15);
    cyc(1'b0, 64'd0, 1'b0, 64'h204, 1'b1, 1'b1, 64'h200);
    cyc(1'b0, 64'd0, 1'b0, 64'h208, 1'b1, 1'b1, 64'h204);

    // Mid-stream reset with flush and stall asserted: reset wins.
    reset = 1'b1;
    i_flush = 1'b1;
    i_branch_target = 64'h300;
    i_stall = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    i_flush = 1'b0;
    chk_reset_state();

    // BOOT ignores stall and restarts from the reset PC.
    cyc(1'b0, 64'd0, 1'b1, 64'h0, 1'b1, 1'b0, 64'h0);
    cyc(1'b0, 64'd0, 1'b0, 64'h4, 1'b1, 1'b1, 64'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
